// File: rtl/mux_addr_ctrl.sv
// mux_addr_ctrl: break-before-make addr/ena sequencer for basic_mux, driven by slow async control pins
module mux_addr_ctrl #(
  parameter int ADDR_W       = 5,
  parameter int NUM_DESIGNS  = 16,
  parameter int GUARD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctrl_sel_rst_n,
  input  logic              ctrl_sel_inc,
  input  logic              ctrl_ena,
  output logic [ADDR_W-1:0] addr,
  output logic              ena,
  output logic              busy
);
  localparam int GW = GUARD_CYCLES > 1 ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_DESIGNS - 1);
  localparam logic [GW-1:0]     GLOAD = GW'(GUARD_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GUARD, ACTIVE} state_t;
  state_t            state_q, state_d;
  logic [1:0]        rst_sync_q, rst_sync_d, inc_sync_q, inc_sync_d, ena_sync_q, ena_sync_d;
  logic              inc_q, inc_d, ena_q, ena_d, busy_q, busy_d;
  logic [ADDR_W-1:0] sel_cnt_q, sel_cnt_d, addr_q, addr_d;
  logic [GW-1:0]     gcnt_q, gcnt_d;
  logic              rst_s, inc_s, ena_s, inc_edge, chg;
  assign rst_s    = rst_sync_q[1];
  assign inc_s    = inc_sync_q[1];
  assign ena_s    = ena_sync_q[1];
  assign inc_edge = inc_s & ~inc_q;
  // a held-low select-reset keeps restarting the guard period
  assign chg      = ~rst_s | inc_edge;
  assign addr     = addr_q;
  assign ena      = ena_q;
  assign busy     = busy_q;
  always_comb begin
    rst_sync_d = {rst_sync_q[0], ctrl_sel_rst_n};
    inc_sync_d = {inc_sync_q[0], ctrl_sel_inc};
    ena_sync_d = {ena_sync_q[0], ctrl_ena};
    inc_d      = inc_s;
    sel_cnt_d  = ~rst_s ? '0 : inc_edge ? (sel_cnt_q == LAST ? '0 : sel_cnt_q + 1'b1) : sel_cnt_q;
    // addr is frozen while enabled, so it only moves after ena has dropped
    addr_d     = state_q == ACTIVE ? addr_q : sel_cnt_q;
    state_d    = state_q;
    gcnt_d     = gcnt_q;
    case (state_q)
      IDLE: begin
        if (ena_s) begin
          state_d = GUARD;
          gcnt_d  = GLOAD;
        end
      end
      GUARD: begin
        if (!ena_s) state_d = IDLE;
        else if (chg) gcnt_d = GLOAD;
        else if (gcnt_q == '0) state_d = ACTIVE;
        else gcnt_d = gcnt_q - 1'b1;
      end
      ACTIVE: begin
        if (!ena_s) state_d = IDLE;
        else if (chg) begin
          state_d = GUARD;
          gcnt_d  = GLOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    ena_d  = state_d == ACTIVE;
    busy_d = state_d == GUARD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b11;
      inc_sync_q <= '0;
      ena_sync_q <= '0;
      inc_q      <= 1'b0;
      sel_cnt_q  <= '0;
      addr_q     <= '0;
      state_q    <= IDLE;
      gcnt_q     <= '0;
      ena_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rst_sync_q <= rst_sync_d;
      inc_sync_q <= inc_sync_d;
      ena_sync_q <= ena_sync_d;
      inc_q      <= inc_d;
      sel_cnt_q  <= sel_cnt_d;
      addr_q     <= addr_d;
      state_q    <= state_d;
      gcnt_q     <= gcnt_d;
      ena_q      <= ena_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_mux_addr_ctrl.sv
// tb_mux_addr_ctrl: scoreboard bench; expected {addr,ena,busy} per edge derived from the pin-to-output latencies
module tb_mux_addr_ctrl;
  typedef logic [6:0] exp_t;
  logic       clk = 1'b0;
  logic       rst_n, ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
  logic [4:0] addr;
  logic       ena, busy;
  exp_t       sb[$];
  exp_t       e;
  int         errors = 0;
  int         checks = 0;
  mux_addr_ctrl #(.ADDR_W(5), .NUM_DESIGNS(16), .GUARD_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc),
    .ctrl_ena(ctrl_ena), .addr(addr), .ena(ena), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_sel_inc = 1'b1;
      repeat (4) tick();
      ctrl_sel_inc = 1'b0;
      repeat (4) tick();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    ctrl_sel_rst_n = 1'b1;
    ctrl_sel_inc = 1'b0;
    ctrl_ena = 1'b0;
    #3;
    checks++;
    if ({addr, ena, busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got addr=%0d ena=%b busy=%b exp all 0", addr, ena, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    ctrl_ena = 1'b1;
    for (int k = 1; k <= 10; k++) sb.push_back(exp_t'({5'd0, k >= 7, k >= 3 && k <= 6}));
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({addr, ena, busy} !== e) begin
        errors++;
        $display("FAIL reset_guard edge=%0d got addr=%0d ena=%b busy=%b exp addr=%0d ena=%b busy=%b",
                 k, addr, ena, busy, e[6:2], e[1], e[0]);
      end
    end
  endtask
  task automatic test_inc();
    for (int p = 0; p < 3; p++)
      for (int k = 1; k <= 8; k++)
        sb.push_back(exp_t'({k <= 3 ? 5'(p) : 5'(p + 1), k <= 2 || k >= 7, k >= 3 && k <= 6}));
    ctrl_sel_inc = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({addr, ena, busy} !== e) begin
        errors++;
        $display("FAIL inc edge=%0d got addr=%0d ena=%b busy=%b exp addr=%0d ena=%b busy=%b",
                 c, addr, ena, busy, e[6:2], e[1], e[0]);
      end
      ctrl_sel_inc = c < 24 && c % 8 < 4;
    end
  endtask
  task automatic test_wrap();
    drive_pulses(12);
    for (int k = 1; k <= 8; k++)
      sb.push_back(exp_t'({k <= 3 ? 5'd15 : 5'd0, k <= 2 || k >= 7, k >= 3 && k <= 6}));
    ctrl_sel_inc = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({addr, ena, busy} !== e) begin
        errors++;
        $display("FAIL wrap edge=%0d got addr=%0d ena=%b busy=%b exp addr=%0d ena=%b busy=%b",
                 c, addr, ena, busy, e[6:2], e[1], e[0]);
      end
      ctrl_sel_inc = c < 4;
    end
  endtask
  task automatic test_sel_rst();
    drive_pulses(5);
    for (int k = 1; k <= 18; k++)
      sb.push_back(exp_t'({k <= 3 ? 5'd5 : 5'd0, k <= 2 || k >= 16, k >= 3 && k <= 15}));
    ctrl_sel_rst_n = 1'b0;
    ctrl_sel_inc = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({addr, ena, busy} !== e) begin
        errors++;
        $display("FAIL sel_rst edge=%0d got addr=%0d ena=%b busy=%b exp addr=%0d ena=%b busy=%b",
                 c, addr, ena, busy, e[6:2], e[1], e[0]);
      end
      ctrl_sel_inc = c < 4;
      ctrl_sel_rst_n = c >= 10;
    end
  endtask
  task automatic test_ena_drop();
    for (int k = 1; k <= 20; k++)
      sb.push_back(exp_t'({5'd0, k <= 2 || k >= 19, (k >= 7 && k <= 10) || (k >= 15 && k <= 18)}));
    ctrl_ena = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({addr, ena, busy} !== e) begin
        errors++;
        $display("FAIL ena_drop edge=%0d got addr=%0d ena=%b busy=%b exp addr=%0d ena=%b busy=%b",
                 c, addr, ena, busy, e[6:2], e[1], e[0]);
      end
      ctrl_ena = (c >= 4 && c < 8) || c >= 12;
    end
  endtask
  task automatic test_async_reset();
    drive_pulses(7);
    checks++;
    if ({addr, ena, busy} !== {5'd7, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL pre_async got addr=%0d ena=%b busy=%b exp addr=7 ena=1 busy=0", addr, ena, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({addr, ena, busy} !== 7'd0) begin
      errors++;
      $display("FAIL async_reset got addr=%0d ena=%b busy=%b exp all 0", addr, ena, busy);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) sb.push_back(exp_t'({5'd0, k >= 7, k >= 3 && k <= 6}));
    for (int k = 1; k <= 10; k++) begin
      tick();
      e = sb.pop_front();
      checks++;
      if ({addr, ena, busy} !== e) begin
        errors++;
        $display("FAIL async_rerun edge=%0d got addr=%0d ena=%b busy=%b exp addr=%0d ena=%b busy=%b",
                 k, addr, ena, busy, e[6:2], e[1], e[0]);
      end
    end
  endtask
  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_sel_rst();
    test_ena_drop();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
